control_raiz: RTL and testbench
===============================

Name: control_raiz

Overview:
Moore FSM controller for the 16-bit restoring square-root core of the calculator. It sequences the remainder/operand shift register (load, 2-bit shift, conditional load of the subtraction result) and the result shift register. It counts iterations and reports completion to the calculator top level through a level handshake. It holds no datapath; it only drives control strobes and samples the subtractor sign bit.

Parameters:
N_ITER, 8, number of root bits / iterations (operand width / 2)
W_CNT, 4, iteration counter width; must satisfy 2**W_CNT > N_ITER

Ports:
CLK    input   1      system clock, rising edge
RST    input   1      synchronous reset, active-high
INIT   input   1      start request, level; sampled only in IDLE
MSB    input   1      sign bit of subtractor output (1 = negative, restore); valid in CHECK
LD     output  1      load operand into shift register, clear remainder and result
SH     output  1      shift {remainder, operand} left by 2
LDA2   output  1      load subtractor result into remainder (datapath gates with !MSB)
R_SH   output  1      shift result register left by 1, inserting R_BIT
R_BIT  output  1      new root bit = ~MSB during CHECK, else 0
BUSY   output  1      high in LOAD, SHIFT, CHECK
DONE   output  1      high in DONE state
ITER   output  W_CNT  remaining iterations

Behaviour:
- Reset: one clock and reset, as decided. Reset is synchronous and active-high. With RST=1 at an edge: state=IDLE, counter=0. All outputs are 0 (ITER=0) from that edge on.
- Reset has priority over every transition, including mid-operation. No partial strobes follow the reset edge.
- All outputs are pure decodes of the state register (Moore). The exceptions are R_BIT = ~MSB, and ITER, which is the counter register.
- States and transitions:
  - IDLE: all strobes 0. INIT=1 -> LOAD.
  - LOAD (1 cycle): LD=1, BUSY=1. Counter <= N_ITER. -> SHIFT.
  - SHIFT (1 cycle): SH=1, BUSY=1. -> CHECK.
  - CHECK (1 cycle): LDA2=1, R_SH=1, R_BIT=~MSB, BUSY=1. Counter <= counter-1.
    - If counter==1 (before decrement) -> DONE.
    - Otherwise -> SHIFT.
  - DONE: DONE=1, other strobes 0. Stays while INIT=1. INIT=0 -> IDLE.
  - Illegal/unused encodings -> IDLE.
- Strobes are mutually exclusive: at most one of LD, SH, LDA2 is high in any cycle. R_SH is high exactly when LDA2 is high.
- Latency: INIT is sampled high at edge 0. LOAD occupies cycle 1. SHIFT/CHECK occupy cycles 2..2*N_ITER+1. DONE is first high after edge 2*N_ITER+2, which is edge 18 for N_ITER=8.
- INIT held high or pulsed while BUSY is ignored. INIT still high in DONE does not restart; a new start requires INIT low for at least one cycle (IDLE) first.
- Counter never wraps. It is decremented only in CHECK and reaches 0 exactly on entry to DONE.
- ITER holds 0 in DONE and IDLE until the next LOAD.

Decomposition:
- Shared package: state encoding constants (S_IDLE, S_LOAD, S_SHIFT, S_CHECK, S_DONE; 3-bit) and the default N_ITER. Other calculator cores reuse the same start/done handshake.
- No sub-module; the counter is inline. An integration wrapper pairing this controller with the square-root datapath is a separate block.

Test Plan:
- Reset: hold RST=1 for 3 cycles with INIT=1 -> all outputs 0, ITER=0. RST low with INIT=1 -> LD=1 on the following cycle.
- Nominal, MSB=0: INIT pulse at edge 0 ->
  - LD high in cycle 1 only.
  - SH high in cycles 2,4,...,16.
  - LDA2=R_SH=1 in cycles 3,5,...,17, with R_BIT=1 in each.
  - ITER 8,7,...,1 across iterations.
  - DONE=1 from cycle 18, ITER=0.
  - Strobes never overlap.
- Alternating sign: MSB=1,0,1,0,... across CHECK cycles -> R_BIT sequence 0,1,0,1,... Only CHECK cycles carry R_SH.
- Handshake: hold INIT=1 through DONE for 5 cycles -> DONE stays 1, no LD. INIT=0 -> IDLE next edge, DONE=0. INIT=1 again -> new LOAD. INIT toggled while BUSY -> no effect on sequence.
- Mid-operation reset: RST=1 at edge 9 -> all outputs 0 after edge 9, ITER=0, state IDLE. Next INIT gives a full 18-cycle sequence.
- Integration with the square-root datapath model:
  - Op_A=144 -> root 12 at DONE.
  - Op_A=16'hFFFF -> 255.
  - Op_A=0 -> 0.
  - Op_A=2 -> 1.

Source files
------------

// File: rtl/control_raiz_pkg.sv
// Shared definitions for the calculator cores that use the level
// start/done handshake: state encoding and default iteration count.
package control_raiz_pkg;

    // 3-bit state encoding; codes 5..7 are unused and recover to IDLE.
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_SHIFT = 3'd2,
        S_CHECK = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Root bits produced for a 16-bit operand.
    localparam int N_ITER_DEFAULT = 8;

endpackage

// File: rtl/control_raiz.sv
// Moore controller for the 16-bit restoring square-root datapath.
// Sequences operand load, 2-bit shifts and conditional remainder
// restores, counts iterations and reports completion.
//
// Handshake: INIT is a level start request sampled only in IDLE. The
// controller answers with BUSY during LOAD/SHIFT/CHECK and then holds
// DONE high for as long as INIT stays high. INIT must drop (one cycle
// in IDLE) before a new operation can start; INIT activity while BUSY
// is ignored.
module control_raiz
    import control_raiz_pkg::*;
#(
    parameter int N_ITER = N_ITER_DEFAULT,
    parameter int W_CNT  = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             INIT,
    input  logic             MSB,
    output logic             LD,
    output logic             SH,
    output logic             LDA2,
    output logic             R_SH,
    output logic             R_BIT,
    output logic             BUSY,
    output logic             DONE,
    output logic [W_CNT-1:0] ITER,
    output logic [2:0]       STATE
);

    localparam logic [W_CNT-1:0] N_ITER_C = W_CNT'(N_ITER);
    localparam logic [W_CNT-1:0] ONE      = W_CNT'(1);

    state_t           state;
    logic [W_CNT-1:0] cnt;

    // State and iteration counter; reset wins over every transition.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (INIT) state <= S_LOAD;
                end
                S_LOAD: begin
                    cnt   <= N_ITER_C;
                    state <= S_SHIFT;
                end
                S_SHIFT: begin
                    state <= S_CHECK;
                end
                S_CHECK: begin
                    // Guarded so the counter can never wrap below zero.
                    if (cnt != '0) cnt <= cnt - ONE;
                    if (cnt <= ONE) state <= S_DONE;
                    else            state <= S_SHIFT;
                end
                S_DONE: begin
                    if (!INIT) state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // Output decode depends only on the state register (plus MSB for R_BIT).
    assign LD    = (state == S_LOAD);
    assign SH    = (state == S_SHIFT);
    assign LDA2  = (state == S_CHECK);
    assign R_SH  = (state == S_CHECK);
    assign R_BIT = (state == S_CHECK) & ~MSB;
    assign BUSY  = (state == S_LOAD) | (state == S_SHIFT) | (state == S_CHECK);
    assign DONE  = (state == S_DONE);
    assign ITER  = cnt;
    assign STATE = state;

endmodule

// File: tb/tb_control_raiz.sv
// Directed bench for control_raiz, including a behavioural model of the
// restoring square-root datapath driven by the controller strobes.
module tb_control_raiz;
    import control_raiz_pkg::*;

    // ---------------- clock / reset ----------------
    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic       INIT = 1'b0;
    logic       msb_drv = 1'b0;
    logic       use_model = 1'b0;
    logic       MSB;
    logic       LD, SH, LDA2, R_SH, R_BIT, BUSY, DONE;
    logic [3:0] ITER;
    logic [2:0] STATE;

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;

    control_raiz dut (
        .CLK   (CLK),
        .RST   (RST),
        .INIT  (INIT),
        .MSB   (MSB),
        .LD    (LD),
        .SH    (SH),
        .LDA2  (LDA2),
        .R_SH  (R_SH),
        .R_BIT (R_BIT),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .ITER  (ITER),
        .STATE (STATE)
    );

    // ---------------- datapath model ----------------
    logic [15:0] op_a = 16'd0;
    logic [15:0] op_q = 16'd0;
    logic [11:0] rem_q = 12'd0;
    logic [7:0]  root_q = 8'd0;
    logic [12:0] diff;
    logic        model_msb;

    assign diff      = {1'b0, rem_q} - {3'b000, root_q, 2'b01};
    assign model_msb = diff[12];
    assign MSB       = use_model ? model_msb : msb_drv;

    always @(posedge CLK) begin
        if (LD) begin
            op_q   <= op_a;
            rem_q  <= 12'd0;
            root_q <= 8'd0;
        end else if (SH) begin
            rem_q <= {rem_q[9:0], op_q[15:14]};
            op_q  <= {op_q[13:0], 2'b00};
        end
        if (LDA2 && !model_msb) rem_q <= diff[11:0];
        if (R_SH) root_q <= {root_q[6:0], R_BIT};
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        RST  = 1'b1;
        INIT = 1'b0;
        tick();
        RST  = 1'b0;
        tick();
    endtask

    // Expected outputs for cycle c of an operation (c=1 is the cycle just
    // after the edge that samples INIT), with INIT low by the DONE cycle.
    // rbit_chk is the root bit expected if c is a CHECK cycle.
    function automatic logic [10:0] exp_vec(int c, logic rbit_chk);
        logic       ld, sh, chk, dn, bsy;
        logic [3:0] it;
        ld  = (c == 1);
        sh  = (c >= 2) && (c <= 16) && (c % 2 == 0);
        chk = (c >= 3) && (c <= 17) && (c % 2 == 1);
        dn  = (c == 18);
        bsy = ld | sh | chk;
        it  = ((c >= 2) && (c <= 17)) ? 4'(8 - (c - 2) / 2) : 4'd0;
        return {ld, sh, chk, chk, chk & rbit_chk, bsy, dn, it};
    endfunction

    function automatic logic [10:0] act_vec();
        return {LD, SH, LDA2, R_SH, R_BIT, BUSY, DONE, ITER};
    endfunction

    // ---------------- tests ----------------
    task automatic test_reset();
        RST  = 1'b1;
        INIT = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (act_vec() !== 11'd0 || STATE !== S_IDLE) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: got %b state %0d, want 0 state 0",
                         i, act_vec(), STATE);
            end
        end
        RST = 1'b0;
        tick();
        checks++;
        if (act_vec() !== exp_vec(1, 1'b0)) begin
            errors++;
            $display("FAIL reset_release: got %b want %b", act_vec(), exp_vec(1, 1'b0));
        end
        apply_reset();
    endtask

    task automatic test_nominal();
        msb_drv = 1'b0;
        for (int c = 1; c <= 19; c++) begin
            INIT = (c == 1);
            tick();
            checks++;
            if (act_vec() !== exp_vec(c, 1'b1)) begin
                errors++;
                $display("FAIL nominal c%0d: got %b want %b", c, act_vec(), exp_vec(c, 1'b1));
            end
            checks++;
            if ((int'(LD) + int'(SH) + int'(LDA2)) > 1 || R_SH !== LDA2) begin
                errors++;
                $display("FAIL strobe_excl c%0d: got ld%b sh%b lda2%b rsh%b want one-hot",
                         c, LD, SH, LDA2, R_SH);
            end
        end
    endtask

    task automatic test_alt_sign();
        for (int c = 1; c <= 19; c++) begin
            logic m;
            m       = (((c - 2) / 2) % 2 == 0);
            msb_drv = (c >= 2) ? m : 1'b0;
            INIT    = (c == 1);
            tick();
            checks++;
            if (act_vec() !== exp_vec(c, ~m)) begin
                errors++;
                $display("FAIL alt_sign c%0d: got %b want %b", c, act_vec(), exp_vec(c, ~m));
            end
        end
        msb_drv = 1'b0;
    endtask

    task automatic test_handshake();
        // INIT held high through the whole run and 5 DONE cycles.
        INIT = 1'b1;
        for (int c = 1; c <= 17; c++) tick();
        for (int k = 0; k < 5; k++) begin
            tick();
            checks++;
            if (DONE !== 1'b1 || LD !== 1'b0 || BUSY !== 1'b0 || ITER !== 4'd0) begin
                errors++;
                $display("FAIL hold_done k%0d: got done%b ld%b busy%b iter%0d want done1 ld0 busy0 iter0",
                         k, DONE, LD, BUSY, ITER);
            end
        end
        INIT = 1'b0;
        tick();
        checks++;
        if (act_vec() !== 11'd0 || STATE !== S_IDLE) begin
            errors++;
            $display("FAIL done_release: got %b state %0d want 0 state 0", act_vec(), STATE);
        end
        // Restart, toggling INIT at random while busy.
        for (int c = 1; c <= 19; c++) begin
            if (c == 1)       INIT = 1'b1;
            else if (c == 19) INIT = 1'b0;
            else              INIT = 1'($urandom_range(0, 1));
            tick();
            checks++;
            if (act_vec() !== exp_vec(c, 1'b1)) begin
                errors++;
                $display("FAIL init_toggle c%0d: got %b want %b", c, act_vec(), exp_vec(c, 1'b1));
            end
        end
    endtask

    task automatic test_mid_reset();
        INIT = 1'b1;
        tick();
        INIT = 1'b0;
        for (int c = 2; c <= 8; c++) tick();
        RST = 1'b1;
        tick();
        checks++;
        if (act_vec() !== 11'd0 || STATE !== S_IDLE) begin
            errors++;
            $display("FAIL mid_reset: got %b state %0d want 0 state 0", act_vec(), STATE);
        end
        RST = 1'b0;
        tick();
        checks++;
        if (act_vec() !== 11'd0) begin
            errors++;
            $display("FAIL mid_reset_idle: got %b want 0", act_vec());
        end
        for (int c = 1; c <= 19; c++) begin
            INIT = (c == 1);
            tick();
            checks++;
            if (act_vec() !== exp_vec(c, 1'b1)) begin
                errors++;
                $display("FAIL after_reset c%0d: got %b want %b", c, act_vec(), exp_vec(c, 1'b1));
            end
        end
    endtask

    task automatic test_sqrt();
        logic [15:0] ops[4]   = '{16'd144, 16'hFFFF, 16'd0, 16'd2};
        logic [7:0]  roots[4] = '{8'd12, 8'd255, 8'd0, 8'd1};
        use_model = 1'b1;
        for (int i = 0; i < 4; i++) begin
            int wait_cnt;
            op_a = ops[i];
            INIT = 1'b1;
            tick();
            INIT = 1'b0;
            wait_cnt = 0;
            while (DONE !== 1'b1 && wait_cnt < 40) begin
                tick();
                wait_cnt++;
            end
            checks++;
            if (DONE !== 1'b1) begin
                errors++;
                $display("FAIL sqrt_timeout op=%0d: got done%b want done1", ops[i], DONE);
            end else if (root_q !== roots[i]) begin
                errors++;
                $display("FAIL sqrt op=%0d: got %0d want %0d", ops[i], root_q, roots[i]);
            end
            tick();
        end
        use_model = 1'b0;
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        apply_reset();
        test_reset();
        test_nominal();
        test_alt_sign();
        test_handshake();
        test_mid_reset();
        test_sqrt();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
